// File: rtl/ps2_reaction_referee.sv
// ps2_reaction_referee
// Brings the PS/2 decoder's p1/p2/space key levels into the CLOCK_50 domain,
// turns them into single-cycle rise events and referees a two-player reaction
// round: space arms, a fixed delay elapses, GO opens, first press wins.
module ps2_reaction_referee #(
    parameter int DELAY_CYCLES   = 50_000_000,
    parameter int TIMEOUT_CYCLES = 150_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       p1,
    input  logic       p2,
    input  logic       space,
    output logic       go_led,
    output logic [1:0] winner,
    output logic       false_start,
    output logic       round_done,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score
);

    localparam int MAX_CYCLES = (DELAY_CYCLES > TIMEOUT_CYCLES) ? DELAY_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES) < 1) ? 1 : $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] DELAY_LOAD   = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_GO     = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    // Saturating score increment: a score parks at 15 until reset.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : (v + 4'd1);
    endfunction

    // Bit order in the synchronizer vectors: [0]=p1, [1]=p2, [2]=space.
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_sync3;
    logic [2:0]       w_rise;
    logic             w_p1_rise;
    logic             w_p2_rise;
    logic             w_space_rise;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_go_led;
    logic [1:0]       r_winner;
    logic             r_false_start;
    logic             r_round_done;
    logic [3:0]       r_p1_score;
    logic [3:0]       r_p2_score;

    // Three-flop chain per key: two flops resolve metastability, the third
    // holds the previous level so only a low-to-high step makes an event.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_sync3 <= 3'b000;
        end else begin
            r_sync1 <= {space, p2, p1};
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rise       = r_sync2 & ~r_sync3;
    assign w_p1_rise    = w_rise[0];
    assign w_p2_rise    = w_rise[1];
    assign w_space_rise = w_rise[2];

    // Round sequencer: state, shared delay/timeout counter and all outputs
    // update together so every result lands on a single edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= CNT_ZERO;
            r_go_led      <= 1'b0;
            r_winner      <= 2'd0;
            r_false_start <= 1'b0;
            r_round_done  <= 1'b0;
            r_p1_score    <= 4'd0;
            r_p2_score    <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RESULT: begin
                    // Player keys are ignored here; only space starts a round.
                    if (w_space_rise) begin
                        r_state       <= ST_WAIT;
                        r_cnt         <= DELAY_LOAD;
                        r_winner      <= 2'd0;
                        r_false_start <= 1'b0;
                        r_round_done  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // Any press before GO is a false start; the other player wins.
                    if (w_p1_rise || w_p2_rise) begin
                        r_state       <= ST_RESULT;
                        r_round_done  <= 1'b1;
                        r_false_start <= 1'b1;
                        case ({w_p2_rise, w_p1_rise})
                            2'b01: begin
                                r_winner   <= 2'd2;
                                r_p2_score <= sat_inc(r_p2_score);
                            end
                            2'b10: begin
                                r_winner   <= 2'd1;
                                r_p1_score <= sat_inc(r_p1_score);
                            end
                            2'b11:   r_winner <= 2'd3;
                            default: r_winner <= r_winner;
                        endcase
                    end else if (r_cnt == CNT_ZERO) begin
                        r_state  <= ST_GO;
                        r_go_led <= 1'b1;
                        r_cnt    <= TIMEOUT_LOAD;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_GO: begin
                    // A press in the same cycle as expiry still counts.
                    if (w_p1_rise || w_p2_rise) begin
                        r_state      <= ST_RESULT;
                        r_round_done <= 1'b1;
                        r_go_led     <= 1'b0;
                        case ({w_p2_rise, w_p1_rise})
                            2'b01: begin
                                r_winner   <= 2'd1;
                                r_p1_score <= sat_inc(r_p1_score);
                            end
                            2'b10: begin
                                r_winner   <= 2'd2;
                                r_p2_score <= sat_inc(r_p2_score);
                            end
                            2'b11:   r_winner <= 2'd3;
                            default: r_winner <= r_winner;
                        endcase
                    end else if (r_cnt == CNT_ZERO) begin
                        r_state      <= ST_RESULT;
                        r_round_done <= 1'b1;
                        r_go_led     <= 1'b0;
                        r_winner     <= 2'd0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_go_led     <= 1'b0;
                    r_round_done <= 1'b0;
                end
            endcase
        end
    end

    assign go_led      = r_go_led;
    assign winner      = r_winner;
    assign false_start = r_false_start;
    assign round_done  = r_round_done;
    assign p1_score    = r_p1_score;
    assign p2_score    = r_p2_score;

endmodule

// File: tb/tb_ps2_reaction_referee.sv
// Scoreboard bench for ps2_reaction_referee (DELAY_CYCLES=8, TIMEOUT_CYCLES=16).
// Stimulus pushes expected results (with the edge they must appear on);
// a monitor pops and compares on every round_done / go_led rising edge.
module tb_ps2_reaction_referee;

    localparam int DLY = 8;
    localparam int TMO = 16;

    typedef struct {
        int         at;
        logic [1:0] w;
        logic       fs;
        int         s1;
        int         s2;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       p1;
    logic       p2;
    logic       space;
    logic       go_led;
    logic [1:0] winner;
    logic       false_start;
    logic       round_done;
    logic [3:0] p1_score;
    logic [3:0] p2_score;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   m_s1    = 0;
    int   m_s2    = 0;
    res_t q_res[$];
    int   q_go[$];

    ps2_reaction_referee #(
        .DELAY_CYCLES  (DLY),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .p1         (p1),
        .p2         (p2),
        .space      (space),
        .go_led     (go_led),
        .winner     (winner),
        .false_start(false_start),
        .round_done (round_done),
        .p1_score   (p1_score),
        .p2_score   (p2_score)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    // Queue an expected result; the model scores update at push time.
    task automatic push_res(input int at, input int w, input bit fs);
        res_t r;
        if (w == 1) m_s1 = sat(m_s1);
        if (w == 2) m_s2 = sat(m_s2);
        r.at = at; r.w = 2'(w); r.fs = fs; r.s1 = m_s1; r.s2 = m_s2;
        q_res.push_back(r);
    endtask

    // Called on a negedge: advance to the negedge following edge 'target'.
    task automatic wait_until(input int target);
        int guard = 0;
        while (cyc < target && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_until_cycle", cyc, target);
    endtask

    // Space pulse; WAIT is entered at edge cyc+3.
    task automatic arm(input bit exp_go, output int e);
        space = 1'b1;
        e = cyc + 3;
        if (exp_go) q_go.push_back(e + DLY);
        @(negedge clk);
        space = 1'b0;
        @(negedge clk);
    endtask

    // Raise the selected keys; the result lands 3 edges after this negedge.
    task automatic press(input bit b1, input bit b2, input int w, input bit fs);
        if (b1) p1 = 1'b1;
        if (b2) p2 = 1'b1;
        push_res(cyc + 3, w, fs);
        repeat (2) @(negedge clk);
        p1 = 1'b0;
        p2 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Monitor: compares DUT events against the scoreboard queues.
    initial begin
        logic prev_rd = 1'b0;
        logic prev_go = 1'b0;
        res_t r;
        int   g;
        forever begin
            @(negedge clk);
            if (round_done && !prev_rd) begin
                if (q_res.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    r = q_res.pop_front();
                    check("result_cycle", cyc, r.at);
                    check("winner", int'(winner), int'(r.w));
                    check("false_start", int'(false_start), int'(r.fs));
                    check("p1_score", int'(p1_score), r.s1);
                    check("p2_score", int'(p2_score), r.s2);
                    check("go_led_at_result", int'(go_led), 0);
                end
            end
            if (!round_done && prev_rd) begin
                check("rearm_winner_clear", int'(winner), 0);
                check("rearm_false_start_clear", int'(false_start), 0);
            end
            if (go_led && !prev_go) begin
                if (q_go.size() == 0) begin
                    check("unexpected_go", 1, 0);
                end else begin
                    g = q_go.pop_front();
                    check("go_cycle", cyc, g);
                    check("round_done_in_go", int'(round_done), 0);
                end
            end
            prev_rd = round_done;
            prev_go = go_led;
        end
    end

    initial begin
        int e;
        rst = 1'b1; p1 = 1'b0; p2 = 1'b0; space = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_go_led", int'(go_led), 0);
        check("rst_winner", int'(winner), 0);
        check("rst_false_start", int'(false_start), 0);
        check("rst_round_done", int'(round_done), 0);
        check("rst_p1_score", int'(p1_score), 0);
        check("rst_p2_score", int'(p2_score), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: normal win for player 1 during GO
        arm(1'b1, e);
        wait_until(e + DLY + 2);
        press(1'b1, 1'b0, 1, 1'b0);

        // 2: false start by player 2 three cycles into WAIT
        arm(1'b0, e);
        wait_until(e + 3);
        press(1'b0, 1'b1, 1, 1'b1);

        // 3a: simultaneous press during GO
        arm(1'b1, e);
        wait_until(e + DLY + 1);
        press(1'b1, 1'b1, 3, 1'b0);

        // 3b: simultaneous press during WAIT
        arm(1'b0, e);
        wait_until(e + 2);
        press(1'b1, 1'b1, 3, 1'b1);

        // 4: timeout with p1 held since before arming (no fresh rise)
        p1 = 1'b1;
        repeat (4) @(negedge clk);
        arm(1'b1, e);
        push_res(e + DLY + TMO, 0, 1'b0);
        wait_until(e + DLY + TMO + 2);
        p1 = 1'b0;
        repeat (3) @(negedge clk);

        // 5: 17 consecutive player-2 wins, score saturates at 15
        for (int i = 0; i < 17; i++) begin
            arm(1'b1, e);
            wait_until(e + DLY + 1);
            press(1'b0, 1'b1, 2, 1'b0);
        end
        check("p2_saturated", int'(p2_score), 15);

        // 6: asynchronous reset mid-GO, then a fresh round
        arm(1'b1, e);
        wait_until(e + DLY + 4);
        check("go_before_reset", int'(go_led), 1);
        #1 rst = 1'b1;
        #1;
        check("async_go_led", int'(go_led), 0);
        check("async_winner", int'(winner), 0);
        check("async_round_done", int'(round_done), 0);
        check("async_p1_score", int'(p1_score), 0);
        check("async_p2_score", int'(p2_score), 0);
        m_s1 = 0;
        m_s2 = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        arm(1'b1, e);
        wait_until(e + DLY + 2);
        press(1'b1, 1'b0, 1, 1'b0);
        repeat (4) @(negedge clk);

        check("results_drained", q_res.size(), 0);
        check("go_events_drained", q_go.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
